// File: rtl/sram_burst_reader.sv
// Burst read master for the single-read-port SRAM: issues contiguous reads
// and streams the returned words through a two-entry buffer.
module sram_burst_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issue_q;
    logic [ADDR_WIDTH:0]   beat_q;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  busy_q;
    logic                  done_q;

    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;
    logic [ADDR_WIDTH-1:0] issue_addr;

    assign pop        = out_valid && out_ready;
    assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign issue      = (state_q == RUN) && (issue_q < len_q)
                        && (occ < 3'd2 + {2'b00, pop});
    assign issue_addr = base_q + issue_q[ADDR_WIDTH-1:0];

    // Address goes out combinationally so the SRAM sees it this cycle.
    assign mem_read_addr = issue ? issue_addr : addr_q;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign out_last  = out_valid
                       && (beat_q == len_q - (ADDR_WIDTH+1)'(1));
    assign busy      = busy_q;
    assign done      = done_q;

    // Shift-style buffer: head is always the oldest word.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (cnt_d == 2'd0) head_d = mem_read_data;
            else               tail_d = mem_read_data;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issue_q    <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            if (issue) begin
                addr_q  <= issue_addr;
                issue_q <= issue_q + (ADDR_WIDTH+1)'(1);
            end
            if (pop) beat_q <= beat_q + (ADDR_WIDTH+1)'(1);
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        base_q  <= base_addr;
                        len_q   <= length;
                        issue_q <= '0;
                        beat_q  <= '0;
                        if (length != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && out_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Randomized bench for sram_burst_reader against an SRAM model and an
// expected-word queue built from base/length arithmetic.
module tb_sram_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic        busy;
    logic        done;
    logic [7:0]  mem_read_addr;
    logic [15:0] mem_read_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;

    logic [15:0] mem [256];
    int          total = 0;
    int          bad = 0;

    sram_burst_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    // Registered-read SRAM: data appears the cycle after the address.
    always @(posedge clk) mem_read_data <= mem[mem_read_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // rmode: 0 always ready (timing checked), 1 fixed toggle, 2 random.
    task automatic run_burst(input logic [7:0] b, input int n,
                             input int rmode, input bit spur);
        logic [15:0] exp_q[$];
        logic [7:0]  eaddr[$];
        logic [7:0]  seen[$];
        int          pat[6] = '{1, 0, 0, 1, 0, 1};
        int          idx = 0;
        int          cyc = 0;
        int          limit = n * 6 + 20;
        bit          got_done = 0;
        bit          prev_stall = 0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[8'(b + 8'(i))]);
            eaddr.push_back(8'(b + 8'(i)));
        end
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        length = 9'(n);
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!got_done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = pat[(cyc - 1) % 6] != 0;
                default: out_ready = $urandom_range(0, 3) != 0;
            endcase
            if (spur) begin
                start = 1'b1;
                base_addr = 8'($urandom);
                length = 9'($urandom);
            end
            #1;
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            chk("fifo_le2", 32'(dut.cnt_q <= 2'd2), 1);
            chk("busy", 32'(busy), 32'(n != 0 && !done));
            if (busy && (seen.size() == 0 || mem_read_addr != seen[$]))
                seen.push_back(mem_read_addr);
            if (out_valid && out_ready) begin
                if (idx < n) begin
                    chk("beat_data", 32'(out_data), 32'(exp_q[idx]));
                    chk("beat_last", 32'(out_last), 32'(idx == n - 1));
                end else begin
                    chk("extra_beat", idx, n);
                end
                if (rmode == 0) chk("beat_cycle", cyc, idx + 3);
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (done) begin
                got_done = 1;
                if (rmode == 0) chk("done_cycle", cyc, (n == 0) ? 1 : n + 3);
                chk("beats", idx, n);
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        chk("addr_count", seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            chk("addr", 32'(seen[i]), 32'(eaddr[i]));
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("done_pulse", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        @(negedge clk);
        #1 chk("start_ignored", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_addr", 32'(mem_read_addr), 0);
        chk("rst_data", 32'(out_data), 0);
        rst = 1'b0;

        run_burst(8'h10, 4, 0, 0);
        run_burst(8'h10, 4, 1, 0);

        mem[8'hFE] = 16'($urandom);
        mem[8'hFF] = 16'($urandom);
        mem[8'h00] = 16'($urandom);
        mem[8'h01] = 16'($urandom);
        run_burst(8'hFE, 4, 0, 0);

        run_burst(8'h00, 0, 0, 0);
        run_burst(8'h40, 8, 0, 1);

        // Reset mid-burst with a stalled consumer.
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'h00;
        length = 9'd16;
        out_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 chk("pre_rst_valid", 32'(out_valid), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_addr", 32'(mem_read_addr), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_last", 32'(out_last), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        run_burst(8'h20, 2, 0, 0);

        run_burst(8'h00, 256, 0, 0);

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int t = 0; t < 6; t++)
            run_burst(8'($urandom), $urandom_range(1, 40), 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
